// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning path.
// Bit indices match the board button order used by the scanning-light controller.
package btn_pkg;

    localparam int BTN_UP     = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_CENTER = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_DOWN   = 4;

    // 100 MHz defaults: 10 ms debounce, 500 ms to first repeat, 100 ms between repeats.
    localparam int DEF_N_BTN           = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM and auto-repeat timer.
// All outputs are registered; pulses last exactly one cycle.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [RCNT_W-1:0] FIRST_TICK = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] NEXT_TICK  = RCNT_W'(REPEAT_PERIOD);
    localparam logic [RCNT_W-1:0] RCNT_ONE   = RCNT_W'(1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_debounce_ch: timing parameters must be >= 1");
    end

    logic              sync1;
    logic              s;
    btn_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_inc;
    logic [RCNT_W-1:0] tick_target;
    logic              first_wait;

    always_comb begin
        rcnt_inc    = rcnt + RCNT_ONE;
        tick_target = first_wait ? FIRST_TICK : NEXT_TICK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b0;
            s             <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            rcnt          <= '0;
            first_wait    <= 1'b1;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync1         <= raw;
            s             <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            unique case (state)
                IDLE: begin
                    level <= 1'b0;
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end

                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_DONE) begin
                        state        <= HELD;
                        level        <= 1'b1;
                        press_pulse  <= 1'b1;
                        repeat_pulse <= 1'b1;
                        cnt          <= '0;
                        rcnt         <= '0;
                        first_wait   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                HELD: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                        rcnt  <= '0;
                    end else if (rcnt_inc == tick_target) begin
                        repeat_pulse <= 1'b1;
                        rcnt         <= '0;
                        first_wait   <= 1'b0;
                    end else begin
                        rcnt <= rcnt_inc;
                    end
                end

                RELEASE_WAIT: begin
                    // A bounce back to high resumes HELD with the long first-repeat delay.
                    if (s) begin
                        state      <= HELD;
                        cnt        <= '0;
                        rcnt       <= '0;
                        first_wait <= 1'b1;
                    end else if (cnt == CNT_DONE) begin
                        state         <= IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board push-buttons into clean levels plus press/release/repeat pulses.
// Channels are independent; simultaneous events pulse in the same cycle.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    if (N_BTN < 1) begin : g_param_check
        $error("button_conditioner: N_BTN must be >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .raw          (btn_raw[i]),
            .level        (btn_level[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i]),
            .repeat_pulse (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timing; pulse expectations are scheduled
// by absolute edge number in a scoreboard and matched by a per-cycle monitor.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int NB  = 5;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = DB + 2;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    button_conditioner #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 press, 1 release, 2 repeat
    } ev_t;

    ev_t sb[$];
    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match a scheduled event; overdue events are misses.
    logic obs;
    int   hit;
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < NB; ch++) begin
                obs = (k == 0) ? btn_press[ch] : (k == 1) ? btn_release[ch] : btn_repeat[ch];
                if (obs === 1'b1) begin
                    hit = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (hit < 0 && sb[i].ch == ch && sb[i].kind == k && sb[i].cyc == cyc)
                            hit = i;
                    tests++;
                    if (hit < 0) begin
                        fails++;
                        $display("FAIL sb_unexpected kind%0d ch%0d edge %0d: got pulse 1, expected 0", k, ch, cyc);
                    end else begin
                        sb.delete(hit);
                    end
                end
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL sb_missed kind%0d ch%0d edge %0d: got pulse 0, expected 1", sb[i].kind, sb[i].ch, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int t, input int ch, input int kind);
        ev_t e;
        e.cyc  = t;
        e.ch   = ch;
        e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        btn_raw = '0;
        step(2);
        tests++; if (btn_level !== 5'b0)   begin fails++; $display("FAIL reset_level got %b want 00000", btn_level); end
        tests++; if (btn_press !== 5'b0)   begin fails++; $display("FAIL reset_press got %b want 00000", btn_press); end
        tests++; if (btn_release !== 5'b0) begin fails++; $display("FAIL reset_release got %b want 00000", btn_release); end
        tests++; if (btn_repeat !== 5'b0)  begin fails++; $display("FAIL reset_repeat got %b want 00000", btn_repeat); end
        rst = 1'b0;
        step(3);
    endtask

    task automatic test_clean_press;
        int a, e1;
        btn_raw[BTN_LEFT] = 1'b1;
        a = cyc + 1 + LAT;
        push_ev(a, BTN_LEFT, 0);
        push_ev(a, BTN_LEFT, 2);
        step(a - 1 - cyc);
        tests++; if (btn_level[BTN_LEFT] !== 1'b0) begin fails++; $display("FAIL clean_level_early got %b want 0", btn_level[BTN_LEFT]); end
        step(1);
        tests++; if (btn_level[BTN_LEFT] !== 1'b1) begin fails++; $display("FAIL clean_level got %b want 1", btn_level[BTN_LEFT]); end
        tests++; if (btn_press[BTN_LEFT] !== 1'b1) begin fails++; $display("FAIL clean_press got %b want 1", btn_press[BTN_LEFT]); end
        step(1);
        tests++; if (btn_press[BTN_LEFT] !== 1'b0) begin fails++; $display("FAIL clean_press_width got %b want 0", btn_press[BTN_LEFT]); end
        btn_raw[BTN_LEFT] = 1'b0;
        e1 = cyc + 1;
        push_ev(e1 + LAT, BTN_LEFT, 1);
        step(e1 + LAT - 1 - cyc);
        tests++; if (btn_level[BTN_LEFT] !== 1'b1) begin fails++; $display("FAIL clean_rel_level_early got %b want 1", btn_level[BTN_LEFT]); end
        step(1);
        tests++; if (btn_level[BTN_LEFT] !== 1'b0) begin fails++; $display("FAIL clean_rel_level got %b want 0", btn_level[BTN_LEFT]); end
        step(3);
    endtask

    task automatic test_bounce;
        int a, e1;
        btn_raw[BTN_UP] = 1'b1;
        step(3);
        btn_raw[BTN_UP] = 1'b0;
        step(1);
        btn_raw[BTN_UP] = 1'b1;
        a = cyc + 1 + LAT;
        push_ev(a, BTN_UP, 0);
        push_ev(a, BTN_UP, 2);
        while (cyc < a - 1) begin
            step(1);
            tests++; if (btn_level[BTN_UP] !== 1'b0) begin fails++; $display("FAIL bounce_level_edge%0d got %b want 0", cyc, btn_level[BTN_UP]); end
        end
        step(1);
        tests++; if (btn_level[BTN_UP] !== 1'b1) begin fails++; $display("FAIL bounce_level got %b want 1", btn_level[BTN_UP]); end
        btn_raw[BTN_UP] = 1'b0;
        e1 = cyc + 1;
        push_ev(e1 + LAT, BTN_UP, 1);
        step(e1 + LAT - cyc);
        tests++; if (btn_level[BTN_UP] !== 1'b0) begin fails++; $display("FAIL bounce_rel_level got %b want 0", btn_level[BTN_UP]); end
        step(3);
    endtask

    task automatic test_auto_repeat;
        int a, e1;
        btn_raw[BTN_DOWN] = 1'b1;
        a  = cyc + 1 + LAT;
        e1 = a + 31;
        push_ev(a, BTN_DOWN, 0);
        push_ev(a, BTN_DOWN, 2);
        for (int t = a + RD; t <= e1 + 1; t += RP) push_ev(t, BTN_DOWN, 2);
        push_ev(e1 + LAT, BTN_DOWN, 1);
        step(a + 30 - cyc);
        tests++; if (btn_level[BTN_DOWN] !== 1'b1) begin fails++; $display("FAIL repeat_level_held got %b want 1", btn_level[BTN_DOWN]); end
        btn_raw[BTN_DOWN] = 1'b0;
        step(e1 + LAT - cyc);
        tests++; if (btn_release[BTN_DOWN] !== 1'b1) begin fails++; $display("FAIL repeat_release got %b want 1", btn_release[BTN_DOWN]); end
        step(4);
    endtask

    task automatic test_release_glitch;
        int a, g, e1;
        btn_raw[BTN_RIGHT] = 1'b1;
        a = cyc + 1 + LAT;
        push_ev(a, BTN_RIGHT, 0);
        push_ev(a, BTN_RIGHT, 2);
        step(a + 2 - cyc);
        btn_raw[BTN_RIGHT] = 1'b0;
        g  = cyc + 1;
        e1 = g + 16;
        // Timer restarts when HELD resumes at edge g+4.
        for (int t = g + 4 + RD; t <= e1 + 1; t += RP) push_ev(t, BTN_RIGHT, 2);
        push_ev(e1 + LAT, BTN_RIGHT, 1);
        step(2);
        btn_raw[BTN_RIGHT] = 1'b1;
        while (cyc < g + 8) begin
            step(1);
            tests++; if (btn_level[BTN_RIGHT] !== 1'b1) begin fails++; $display("FAIL glitch_level_edge%0d got %b want 1", cyc, btn_level[BTN_RIGHT]); end
        end
        step(e1 - 1 - cyc);
        btn_raw[BTN_RIGHT] = 1'b0;
        step(e1 + LAT - cyc);
        tests++; if (btn_level[BTN_RIGHT] !== 1'b0) begin fails++; $display("FAIL glitch_rel_level got %b want 0", btn_level[BTN_RIGHT]); end
        step(3);
    endtask

    task automatic test_release;
        int a, e1;
        btn_raw[BTN_CENTER] = 1'b1;
        a  = cyc + 1 + LAT;
        e1 = a + 13;
        push_ev(a, BTN_CENTER, 0);
        push_ev(a, BTN_CENTER, 2);
        for (int t = a + RD; t <= e1 + 1; t += RP) push_ev(t, BTN_CENTER, 2);
        push_ev(e1 + LAT, BTN_CENTER, 1);
        step(e1 - 1 - cyc);
        btn_raw[BTN_CENTER] = 1'b0;
        step(e1 + LAT - 1 - cyc);
        tests++; if (btn_level[BTN_CENTER] !== 1'b1) begin fails++; $display("FAIL release_level_early got %b want 1", btn_level[BTN_CENTER]); end
        step(1);
        tests++; if (btn_level[BTN_CENTER] !== 1'b0) begin fails++; $display("FAIL release_level got %b want 0", btn_level[BTN_CENTER]); end
        tests++; if (btn_release[BTN_CENTER] !== 1'b1) begin fails++; $display("FAIL release_pulse got %b want 1", btn_release[BTN_CENTER]); end
        step(1);
        tests++; if (btn_release[BTN_CENTER] !== 1'b0) begin fails++; $display("FAIL release_width got %b want 0", btn_release[BTN_CENTER]); end
        step(15);
    endtask

    task automatic test_reset_mid_press;
        int a, e1;
        btn_raw = '1;
        step(3);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            tests++; if ({btn_level, btn_press, btn_release, btn_repeat} !== 20'b0)
                begin fails++; $display("FAIL midrst_outputs got %b want 0", {btn_level, btn_press, btn_release, btn_repeat}); end
        end
        rst = 1'b0;
        a = cyc + 1 + LAT;
        for (int ch = 0; ch < NB; ch++) begin
            push_ev(a, ch, 0);
            push_ev(a, ch, 2);
        end
        step(a - 1 - cyc);
        tests++; if (btn_level !== 5'b00000) begin fails++; $display("FAIL midrst_level_early got %b want 00000", btn_level); end
        step(1);
        tests++; if (btn_level !== 5'b11111) begin fails++; $display("FAIL midrst_level got %b want 11111", btn_level); end
        tests++; if (btn_press !== 5'b11111) begin fails++; $display("FAIL midrst_press got %b want 11111", btn_press); end
        btn_raw = '0;
        e1 = cyc + 1;
        for (int ch = 0; ch < NB; ch++) push_ev(e1 + LAT, ch, 1);
        step(e1 + LAT - cyc);
        tests++; if (btn_release !== 5'b11111) begin fails++; $display("FAIL midrst_release got %b want 11111", btn_release); end
        tests++; if (btn_level !== 5'b00000) begin fails++; $display("FAIL midrst_rel_level got %b want 00000", btn_level); end
        step(3);
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_release();
        test_reset_mid_press();
        step(12);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d pending events, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream conditioning stage for the board push-buttons (btnu, btnl, btnc, btnr, btnd) that drive the scanning-light controller.
- Synchronises each raw button, debounces it, and emits a clean level plus single-cycle press, release and auto-repeat pulses.
- The downstream controller consumes the pulses directly for mode select and speed up/down, with no edge-detect latches of its own.
- Channels are fully independent, one per button.

Parameters:
- N_BTN, 5, number of button channels; bit map: 0=up, 1=left, 2=center, 3=right, 4=down.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a change (10 ms at 100 MHz); must be >=1.
- REPEAT_DELAY, 50000000, cycles from accepted press to first auto-repeat pulse; must be >=1.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses; must be >=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button inputs, active-high.
- btn_level  out  N_BTN  debounced button state.
- btn_press  out  N_BTN  one-cycle pulse on accepted press.
- btn_release  out  N_BTN  one-cycle pulse on accepted release.
- btn_repeat  out  N_BTN  one-cycle pulse on accepted press and on each auto-repeat tick.

Behaviour:
- Reset: while rst is high at a clock edge, sync flops, counters, btn_level, btn_press, btn_release and btn_repeat all become 0, and every channel enters IDLE. Applies mid-operation with no pulse emitted.
- Synchroniser: two flops per channel; s = second flop output.
- Per-channel FSM has four states:
  - IDLE: level=0. s=1 -> PRESS_WAIT with cnt=1.
  - PRESS_WAIT: s=1 and cnt=DEBOUNCE_CYCLES -> HELD; level<=1, press and repeat pulse this edge, rcnt<=0. s=1 otherwise -> cnt++. s=0 -> IDLE, cnt<=0, no pulse.
  - HELD: level=1. s=0 -> RELEASE_WAIT with cnt=1, rcnt<=0. s=1 -> rcnt++; on reaching REPEAT_DELAY (first tick) or REPEAT_PERIOD (later ticks), pulse repeat and rcnt<=0.
  - RELEASE_WAIT: level stays 1, no repeat pulses. s=0 and cnt=DEBOUNCE_CYCLES -> IDLE; level<=0, release pulse. s=0 otherwise -> cnt++. s=1 -> HELD, rcnt restarts at 0, still waiting for the first-delay tick; no press pulse.
- Latency: btn_raw sampled high at edge 0 and held stable -> btn_level and btn_press go high after edge DEBOUNCE_CYCLES+2. Release is symmetric.
- A bounce that breaks stability before acceptance produces no output change.
- A button held continuously through reset deassertion produces a press exactly as above, counted from the first edge with rst=0.
- Pulses are registered outputs, high for exactly one cycle.
- Simultaneous presses on several channels pulse in the same cycle; arbitration belongs to the consumer.
- Width rules:
  - cnt width is $clog2(DEBOUNCE_CYCLES+1).
  - rcnt width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - Counters never wrap: each is cleared on every transition that uses it.
- An elaboration-time check rejects any parameter below 1.

Decomposition:
- Package btn_pkg holds:
  - bit-index constants BTN_UP=0, BTN_LEFT=1, BTN_CENTER=2, BTN_RIGHT=3, BTN_DOWN=4;
  - the channel state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - the default timing constants.
- One sub-module, btn_debounce_ch, is a single channel (synchroniser + FSM + counters). It is instantiated N_BTN times via generate.

Test Plan (sim params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=5):
- Clean press: btn_raw[1] 0->1 at edge 0, held -> btn_level[1] and btn_press[1] rise after edge 6; btn_press[1] high for exactly 1 cycle; btn_repeat[1] is coincident with the press.
- Bounce: btn_raw[0] high for 3 cycles, low for 1, then high steadily -> no pulse during the glitch; press accepted 6 edges after the final rise.
- Auto-repeat: btn_raw[4] held for 30 cycles after acceptance -> btn_repeat[4] pulses at acceptance, +10, +13, +16, ...; btn_press[4] pulses once only.
- Release glitch: while held, btn_raw[3] low for 2 cycles, then high -> btn_level[3] stays 1, no release pulse, repeat timer restarts (next repeat 10 cycles later).
- Release: held btn_raw[2] goes low steadily -> btn_release[2] pulses and btn_level[2] falls 6 edges later; no further repeats.
- Reset mid-press: assert rst during PRESS_WAIT with btn_raw=5'b11111 held -> all outputs 0 during rst; after deassertion all five channels press simultaneously 6 edges later.
